// File: rtl/pp_buffer_pkg.sv
// Shared types and helpers for the multi-bank stream buffer.
package pp_buffer_pkg;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_DRAIN,
        RD_WAIT
    } rd_state_t;

    // Pointer/address width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pp_bank_mem.sv
// One bank of storage: simple dual-port RAM, one write port, one registered read port.
module pp_bank_mem
    import pp_buffer_pkg::*;
#(
    parameter int DW     = 64,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DW-1:0]     i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DW-1:0]     o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Registered read; output holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/pp_multibank_stream_buffer.sv
// Ring of NUM_BANKS buffers: producer fills banks in order, consumer drains full banks
// in order, replaying each bank cfg_reuse times. Read path is RAM stage plus output register.
//
//  state    | meaning
//  RD_IDLE  | waiting for bank[rd_ptr] to be FULL; issues the first read on start
//  RD_DRAIN | issuing reads, wrapping address per pass
//  RD_WAIT  | final read issued; waiting for the last word to be accepted
module pp_multibank_stream_buffer
    import pp_buffer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_LANES = 4,
    parameter int NUM_BANKS = 2,
    parameter int DEPTH     = 64,
    parameter int REUSE_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic [REUSE_W-1:0]           i_cfg_reuse,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [NUM_LANES*WIDTH-1:0]   i_wr_data,
    input  logic                         i_wr_last,
    output logic                         o_rd_valid,
    input  logic                         i_rd_ready,
    output logic [NUM_LANES*WIDTH-1:0]   o_rd_data,
    output logic                         o_rd_last,
    output logic [$clog2(NUM_BANKS)-1:0] o_rd_bank,
    output logic [NUM_BANKS-1:0]         o_bank_full,
    output logic                         o_ovf_err
);

    localparam int DW     = NUM_LANES * WIDTH;
    localparam int ADDR_W = clog2_min1(DEPTH);
    localparam int BANK_W = clog2_min1(NUM_BANKS);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bank_state_t        r_bank_state [NUM_BANKS];
    logic [CNT_W-1:0]   r_fill_cnt   [NUM_BANKS];
    logic [DW-1:0]      w_bank_rdata [NUM_BANKS];
    logic [BANK_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [ADDR_W-1:0]  r_wr_addr, r_rd_addr, w_issue_addr;
    logic [REUSE_W-1:0] r_pass, r_passes, w_issue_pass, w_issue_passes;
    rd_state_t          r_rd_state, w_rd_state_nxt;
    logic               r_s1_valid, r_s1_last, r_out_valid, r_out_last, r_ovf_err;
    logic [DW-1:0]      r_out_data, w_s1_data;
    logic               w_wr_ready, w_wr_acc, w_wr_close, w_rd_acc, w_s1_move, w_s1_free;
    logic               w_issue, w_start, w_release, w_end_of_pass, w_final;
    logic [NUM_BANKS-1:0] w_bank_full;

    assign w_wr_ready = (r_bank_state[r_wr_ptr] == BANK_FREE) ||
                        (r_bank_state[r_wr_ptr] == BANK_FILLING);
    assign w_wr_acc   = i_wr_valid & w_wr_ready & ~i_flush;
    assign w_wr_close = i_wr_last | (r_wr_addr == LAST_ADDR);

    // Two-entry read pipeline: RAM stage (s1) feeds the output register.
    assign w_rd_acc  = r_out_valid & i_rd_ready;
    assign w_s1_move = r_s1_valid & (~r_out_valid | w_rd_acc);
    assign w_s1_free = ~r_s1_valid | w_s1_move;
    assign w_s1_data = w_bank_rdata[r_rd_ptr];

    // In IDLE the first read of a new bank is issued directly, so counters start from zero.
    assign w_issue_addr   = (r_rd_state == RD_IDLE) ? '0 : r_rd_addr;
    assign w_issue_pass   = (r_rd_state == RD_IDLE) ? '0 : r_pass;
    assign w_issue_passes = (r_rd_state != RD_IDLE) ? r_passes :
                            (i_cfg_reuse == '0)     ? REUSE_W'(1) : i_cfg_reuse;
    assign w_end_of_pass  = ({1'b0, w_issue_addr} == (r_fill_cnt[r_rd_ptr] - CNT_W'(1)));
    assign w_final        = w_end_of_pass && (w_issue_pass == (w_issue_passes - REUSE_W'(1)));

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        pp_bank_mem #(.DW(DW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
            .clk     (clk),
            .i_we    (w_wr_acc && (r_wr_ptr == BANK_W'(k))),
            .i_waddr (r_wr_addr),
            .i_wdata (i_wr_data),
            .i_re    (w_issue && (r_rd_ptr == BANK_W'(k))),
            .i_raddr (w_issue_addr),
            .o_rdata (w_bank_rdata[k])
        );
        assign w_bank_full[k] = (r_bank_state[k] == BANK_FULL) || (r_bank_state[k] == BANK_DRAINING);
    end

    // Read FSM next-state and issue decisions.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_issue        = 1'b0;
        w_start        = 1'b0;
        w_release      = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if ((r_bank_state[r_rd_ptr] == BANK_FULL) && w_s1_free) begin
                    w_issue        = 1'b1;
                    w_start        = 1'b1;
                    w_rd_state_nxt = w_final ? RD_WAIT : RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (w_s1_free) begin
                    w_issue = 1'b1;
                    if (w_final) w_rd_state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (w_rd_acc && r_out_last) begin
                    w_release      = 1'b1;
                    w_rd_state_nxt = RD_IDLE;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_rd_state <= RD_IDLE;
        else if (i_flush) r_rd_state <= RD_IDLE;
        else              r_rd_state <= w_rd_state_nxt;
    end

    // Write pointer, write address, fill counts and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_wr_addr <= '0;
            r_ovf_err <= 1'b0;
            for (int k = 0; k < NUM_BANKS; k++) r_fill_cnt[k] <= '0;
        end else if (i_flush) begin
            r_wr_ptr  <= '0;
            r_wr_addr <= '0;
            r_ovf_err <= 1'b0;
            for (int k = 0; k < NUM_BANKS; k++) r_fill_cnt[k] <= '0;
        end else begin
            if (w_wr_acc) begin
                if (w_wr_close) begin
                    r_fill_cnt[r_wr_ptr] <= {1'b0, r_wr_addr} + CNT_W'(1);
                    r_wr_ptr  <= (r_wr_ptr == LAST_BANK) ? '0 : r_wr_ptr + 1'b1;
                    r_wr_addr <= '0;
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end
            if (i_wr_valid && !w_wr_ready && (r_bank_state[r_wr_ptr] == BANK_FILLING))
                r_ovf_err <= 1'b1;
        end
    end

    // Bank state: read side owns FULL->DRAINING->FREE, write side owns FREE->FILLING->FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BANKS; k++) r_bank_state[k] <= BANK_FREE;
        end else if (i_flush) begin
            for (int k = 0; k < NUM_BANKS; k++) r_bank_state[k] <= BANK_FREE;
        end else begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                if (w_release && (r_rd_ptr == BANK_W'(k)))
                    r_bank_state[k] <= BANK_FREE;
                else if (w_start && (r_rd_ptr == BANK_W'(k)))
                    r_bank_state[k] <= BANK_DRAINING;
                else if (w_wr_acc && (r_wr_ptr == BANK_W'(k)))
                    r_bank_state[k] <= w_wr_close ? BANK_FULL : BANK_FILLING;
            end
        end
    end

    // Read address/pass counters, RAM-stage valid and bank sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_rd_addr  <= '0;
            r_pass     <= '0;
            r_passes   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else if (i_flush) begin
            r_rd_ptr   <= '0;
            r_rd_addr  <= '0;
            r_pass     <= '0;
            r_passes   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_s1_valid <= 1'b1;
                r_s1_last  <= w_final;
                if (w_end_of_pass) begin
                    r_rd_addr <= '0;
                    r_pass    <= w_issue_pass + 1'b1;
                end else begin
                    r_rd_addr <= w_issue_addr + 1'b1;
                    r_pass    <= w_issue_pass;
                end
            end else if (w_s1_move) begin
                r_s1_valid <= 1'b0;
            end
            if (w_start)   r_passes <= w_issue_passes;
            if (w_release) r_rd_ptr <= (r_rd_ptr == LAST_BANK) ? '0 : r_rd_ptr + 1'b1;
        end
    end

    // Output register: holds data/last stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_s1_move) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_s1_data;
            r_out_last  <= r_s1_last;
        end else if (w_rd_acc) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_wr_ready  = w_wr_ready;
    assign o_rd_valid  = r_out_valid;
    assign o_rd_data   = r_out_data;
    assign o_rd_last   = r_out_last;
    assign o_rd_bank   = r_rd_ptr;
    assign o_bank_full = w_bank_full;
    assign o_ovf_err   = r_ovf_err;

endmodule

// File: tb/tb_pp_multibank_stream_buffer.sv
// Bench: a 2-bank and a 3-bank instance (DEPTH=4) with a scoreboard of expected read words.
module tb_pp_multibank_stream_buffer;

    localparam int DW = 64;
    localparam int D  = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [1:0]    bank;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [3:0]    cfg_reuse;
    logic          wr_valid [2];
    logic          wr_ready [2];
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          rd_ready;
    logic          rd_valid [2];
    logic [DW-1:0] rd_data  [2];
    logic          rd_last  [2];
    logic [1:0]    rd_bank  [2];
    logic          ovf_err  [2];
    logic [0:0]    rd_bank_a;
    logic [1:0]    rd_bank_b;
    logic [1:0]    bank_full_a;
    logic [2:0]    bank_full_b;

    int total = 0;
    int bad   = 0;

    exp_t          exp_q0 [$];
    exp_t          exp_q1 [$];
    logic [DW-1:0] fill_buf [2][D];
    int            fill_n    [2];
    int            fill_bank [2];
    bit            rnd_en;

    assign rd_bank[0] = {1'b0, rd_bank_a};
    assign rd_bank[1] = rd_bank_b;

    pp_multibank_stream_buffer #(.WIDTH(16), .NUM_LANES(4), .NUM_BANKS(2), .DEPTH(D), .REUSE_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_cfg_reuse(cfg_reuse),
        .i_wr_valid(wr_valid[0]), .o_wr_ready(wr_ready[0]), .i_wr_data(wr_data), .i_wr_last(wr_last),
        .o_rd_valid(rd_valid[0]), .i_rd_ready(rd_ready), .o_rd_data(rd_data[0]), .o_rd_last(rd_last[0]),
        .o_rd_bank(rd_bank_a), .o_bank_full(bank_full_a), .o_ovf_err(ovf_err[0])
    );

    pp_multibank_stream_buffer #(.WIDTH(16), .NUM_LANES(4), .NUM_BANKS(3), .DEPTH(D), .REUSE_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_cfg_reuse(cfg_reuse),
        .i_wr_valid(wr_valid[1]), .o_wr_ready(wr_ready[1]), .i_wr_data(wr_data), .i_wr_last(wr_last),
        .o_rd_valid(rd_valid[1]), .i_rd_ready(rd_ready), .o_rd_data(rd_data[1]), .o_rd_last(rd_last[1]),
        .o_rd_bank(rd_bank_b), .o_bank_full(bank_full_b), .o_ovf_err(ovf_err[1])
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model of one fill: on bank close, queue every replayed word.
    task automatic model_write(input int d);
        exp_t e;
        int   passes;
        int   nb;
        nb = (d == 0) ? 2 : 3;
        fill_buf[d][fill_n[d]] = wr_data;
        fill_n[d]++;
        if (wr_last || fill_n[d] == D) begin
            passes = (cfg_reuse == 0) ? 1 : int'(cfg_reuse);
            for (int p = 0; p < passes; p++) begin
                for (int i = 0; i < fill_n[d]; i++) begin
                    e.data = fill_buf[d][i];
                    e.last = (p == passes - 1) && (i == fill_n[d] - 1);
                    e.bank = 2'(fill_bank[d]);
                    if (d == 0) exp_q0.push_back(e);
                    else        exp_q1.push_back(e);
                end
            end
            fill_bank[d] = (fill_bank[d] + 1) % nb;
            fill_n[d]    = 0;
        end
    endtask

    task automatic check_read(input int d);
        exp_t  e;
        bit    have;
        string pfx;
        pfx  = (d == 0) ? "a" : "b";
        have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        check_val({pfx, "_rd_expected"}, have, 1'b1);
        if (have) begin
            e = (d == 0) ? exp_q0[0] : exp_q1[0];
            check_val({pfx, "_rd_data"}, rd_data[d], e.data);
            check_val({pfx, "_rd_last"}, rd_last[d], e.last);
            check_val({pfx, "_rd_bank"}, rd_bank[d], e.bank);
            if (rd_ready) begin
                if (d == 0) void'(exp_q0.pop_front());
                else        void'(exp_q1.pop_front());
            end
        end
    endtask

    // Monitor: sample handshakes mid-cycle, feed the model and compare reads.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q0.delete();
            exp_q1.delete();
            for (int d = 0; d < 2; d++) begin
                fill_n[d]    = 0;
                fill_bank[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (wr_valid[d] && wr_ready[d]) model_write(d);
                if (rd_valid[d]) check_read(d);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int sel, input logic [DW-1:0] data, input logic last);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        wr_valid[sel] = 1'b1;
        wr_data       = data;
        wr_last       = last;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = wr_ready[sel];
            step();
            n++;
        end
        check_val("put_accepted", acc, 1'b1);
        wr_valid[sel] = 1'b0;
        wr_last       = 1'b0;
    endtask

    task automatic drain_wait(input int sel);
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done && n < 600) begin
            @(negedge clk);
            #1;
            n++;
            done = ((sel == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) && !rd_valid[sel];
        end
        check_val("drain_done", done, 1'b1);
        step();
    endtask

    initial begin
        int n;
        wr_valid[0] = 1'b0;
        wr_valid[1] = 1'b0;
        wr_data     = '0;
        wr_last     = 1'b0;
        rd_ready    = 1'b1;
        cfg_reuse   = 4'd1;
        flush       = 1'b0;
        rst_n       = 1'b0;
        rnd_en      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // reset state
        check_val("rst_wr_ready_a", wr_ready[0], 1'b1);
        check_val("rst_wr_ready_b", wr_ready[1], 1'b1);
        check_val("rst_rd_valid_a", rd_valid[0], 1'b0);
        check_val("rst_rd_data_a", rd_data[0], 64'h0);
        check_val("rst_bank_full_a", bank_full_a, 2'b00);
        check_val("rst_bank_full_b", bank_full_b, 3'b000);
        check_val("rst_ovf_a", ovf_err[0], 1'b0);

        // 1: single bank fill closed by DEPTH-1, reuse 1, latency check
        for (int i = 1; i <= 4; i++) put(0, DW'(i), 1'b0);
        check_val("t1_bank0_full", bank_full_a, 2'b01);
        check_val("t1_lat0", rd_valid[0], 1'b0);
        step();
        check_val("t1_lat1", rd_valid[0], 1'b0);
        step();
        check_val("t1_lat2", rd_valid[0], 1'b1);
        drain_wait(0);
        check_val("t1_bank_free", bank_full_a, 2'b00);

        // 2: reuse 3 over a 3-word bank closed by wr_last
        cfg_reuse = 4'd3;
        put(0, 64'hA, 1'b0);
        put(0, 64'hB, 1'b0);
        put(0, 64'hC, 1'b1);
        drain_wait(0);

        // 3: consumer stalled, both banks fill, writer backpressured
        cfg_reuse = 4'd1;
        rd_ready  = 1'b0;
        for (int i = 0; i < 8; i++) put(0, 64'h100 + DW'(i), 1'b0);
        wr_valid[0] = 1'b1;
        wr_data     = 64'hDEAD;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_val("t3_wr_blocked", wr_ready[0], 1'b0);
            check_val("t3_ovf_clear", ovf_err[0], 1'b0);
        end
        wr_valid[0] = 1'b0;
        check_val("t3_both_full", bank_full_a, 2'b11);
        step();
        rd_ready = 1'b1;
        drain_wait(0);
        check_val("t3_ovf_after", ovf_err[0], 1'b0);

        // 4: random consumer stalls, reuse 2, includes wr_last on the DEPTH-1 word
        cfg_reuse = 4'd2;
        rnd_en    = 1'b1;
        fork
            begin
                while (rnd_en) begin
                    step();
                    rd_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 3; i++) put(0, {$urandom, $urandom}, i == 2);
        for (int i = 0; i < 4; i++) put(0, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < 4; i++) put(0, {$urandom, $urandom}, i == 3);
        repeat (20) step();
        rnd_en = 1'b0;
        step();
        step();
        rd_ready = 1'b1;
        drain_wait(0);
        check_val("t4_banks_free", bank_full_a, 2'b00);

        // 5: three-bank ring, back-to-back fills, order 0,1,2,0
        cfg_reuse = 4'd1;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 4; i++) put(1, 64'h500 + DW'(f * 16 + i), 1'b0);
        put(1, 64'h5F0, 1'b0);
        put(1, 64'h5F1, 1'b1);
        drain_wait(1);
        check_val("t5_banks_free", bank_full_b, 3'b000);

        // 6a: flush mid-drain
        cfg_reuse = 4'd2;
        for (int i = 0; i < 4; i++) put(0, 64'h600 + DW'(i), 1'b0);
        n = 0;
        while (!rd_valid[0] && n < 20) begin
            step();
            n++;
        end
        check_val("t6_drain_started", rd_valid[0], 1'b1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_val("t6_flush_rd_valid", rd_valid[0], 1'b0);
        check_val("t6_flush_rd_data", rd_data[0], 64'h0);
        check_val("t6_flush_bank_full", bank_full_a, 2'b00);
        check_val("t6_flush_wr_ready", wr_ready[0], 1'b1);
        cfg_reuse = 4'd1;
        for (int i = 0; i < 4; i++) put(0, 64'h700 + DW'(i), 1'b0);
        drain_wait(0);

        // 6b: async reset mid-fill
        put(0, 64'h801, 1'b0);
        put(0, 64'h802, 1'b0);
        rst_n = 1'b0;
        step();
        check_val("t6_rst_bank_full", bank_full_a, 2'b00);
        check_val("t6_rst_rd_valid", rd_valid[0], 1'b0);
        check_val("t6_rst_wr_ready", wr_ready[0], 1'b1);
        rst_n = 1'b1;
        step();
        put(0, 64'h901, 1'b0);
        put(0, 64'h902, 1'b1);
        drain_wait(0);
        check_val("t6_final_free", bank_full_a, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
